grid_io_param_top: RTL and testbench

//  Parametrised IO grid tile: NUM_PADS pad cells sharing one configuration chain (ccff).

---
 rtl/io_grid_pkg.sv | 9 +
 rtl/grid_io_param_top_pad.sv | 35 +++
 rtl/grid_io_param_top.sv | 53 +++++
 tb/tb_grid_io_param_top.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/io_grid_pkg.sv
// io_grid_pkg: per-pad config word layout shared by the IO grid tile and its pad cells
package io_grid_pkg;
    localparam int CFG_W    = 4;
    localparam int CFG_DIR  = 0;
    localparam int CFG_OINV = 1;
    localparam int CFG_OREG = 2;
    localparam int CFG_IREG = 3;
    typedef logic [CFG_W-1:0] io_cfg_t;
endpackage

// File: rtl/grid_io_param_top_pad.sv
// io_pad_cell: one pad datapath (invert, OREG/IREG, isolation).
// IO_INPUT_SYNC_EN adds a 2-flop synchronizer on soc_in ahead of the IREG mux.
module io_pad_cell
    import io_grid_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [CFG_W-1:0] cfg,
    input  logic             isol_n,
    input  logic             soc_in,
    input  logic             fabric_outpad,
    output logic             soc_out,
    output logic             soc_dir,
    output logic             fabric_inpad
);
    logic d, s, oreg, ireg;
`ifdef IO_INPUT_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk) sync <= rst ? 2'b00 : {sync[0], soc_in};
    assign s = sync[1];
`else
    assign s = soc_in;
`endif
    assign d = fabric_outpad ^ cfg[CFG_OINV];
    always_ff @(posedge clk) begin
        oreg <= rst ? 1'b0 : d;
        ireg <= rst ? 1'b0 : s;
    end
    // Output-mode pads never loop back into the fabric.
    always_comb begin
        soc_dir      = isol_n & cfg[CFG_DIR];
        soc_out      = isol_n & (cfg[CFG_OREG] ? oreg : d);
        fabric_inpad = isol_n & ~cfg[CFG_DIR] & (cfg[CFG_IREG] ? ireg : s);
    end
endmodule

// File: rtl/grid_io_param_top.sv
// grid_io_param_top: NUM_PADS IO pads sharing one shadowed config chain with load counter.
// Optional macro IO_INPUT_SYNC_EN enables input synchronizers in every pad cell.
module grid_io_param_top
    import io_grid_pkg::*;
#(
    parameter int NUM_PADS = 4
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                isol_n,
    input  logic                ccff_en,
    input  logic                ccff_head,
    input  logic                cfg_commit,
    input  logic [NUM_PADS-1:0] gfpga_pad_io_soc_in,
    output logic [NUM_PADS-1:0] gfpga_pad_io_soc_out,
    output logic [NUM_PADS-1:0] gfpga_pad_io_soc_dir,
    input  logic [NUM_PADS-1:0] fabric_outpad,
    output logic [NUM_PADS-1:0] fabric_inpad,
    output logic                ccff_tail,
    output logic                cfg_done
);
    localparam int L     = NUM_PADS * CFG_W;
    localparam int CNT_W = $clog2(L + 1);
    logic [L-1:0]     chain, active;
    logic [CNT_W-1:0] cnt;
    // Commit samples the pre-shift chain when it coincides with a shift.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            chain  <= '0;
            active <= '0;
            cnt    <= '0;
        end else begin
            if (ccff_en) chain <= {chain[L-2:0], ccff_head};
            if (cfg_commit) active <= chain;
            if (ccff_en && !cfg_done) cnt <= cnt + CNT_W'(1);
        end
    end
    assign cfg_done  = cnt == CNT_W'(L);
    assign ccff_tail = chain[L-1];
    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        io_pad_cell u_pad (
            .clk          (prog_clk),
            .rst          (pReset),
            .cfg          (active[p*CFG_W +: CFG_W]),
            .isol_n       (isol_n),
            .soc_in       (gfpga_pad_io_soc_in[p]),
            .fabric_outpad(fabric_outpad[p]),
            .soc_out      (gfpga_pad_io_soc_out[p]),
            .soc_dir      (gfpga_pad_io_soc_dir[p]),
            .fabric_inpad (fabric_inpad[p])
        );
    end
endmodule

// File: tb/tb_grid_io_param_top.sv
// tb_grid_io_param_top: directed + random stimulus against a queue/history reference model.
module tb_grid_io_param_top;
    localparam int N = 4;
    localparam int L = 16;
`ifdef IO_INPUT_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif
    logic prog_clk = 1'b0;
    logic pReset, isol_n, ccff_en, ccff_head, cfg_commit;
    logic [N-1:0] soc_in, soc_out, soc_dir, fo, fi;
    logic ccff_tail, cfg_done;
    int total = 0;
    int bad = 0;
    bit chain_q[$];
    logic [3:0] acfg [N];
    logic [N-1:0] d_last;
    logic [N-1:0] h [3];
    int cnt;

    always #5 prog_clk = ~prog_clk;

    grid_io_param_top #(.NUM_PADS(N)) dut (
        .prog_clk            (prog_clk),
        .pReset              (pReset),
        .isol_n              (isol_n),
        .ccff_en             (ccff_en),
        .ccff_head           (ccff_head),
        .cfg_commit          (cfg_commit),
        .gfpga_pad_io_soc_in (soc_in),
        .gfpga_pad_io_soc_out(soc_out),
        .gfpga_pad_io_soc_dir(soc_dir),
        .fabric_outpad       (fo),
        .fabric_inpad        (fi),
        .ccff_tail           (ccff_tail),
        .cfg_done            (cfg_done)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        chain_q = {};
        for (int i = 0; i < L; i++) chain_q.push_back(1'b0);
        for (int p = 0; p < N; p++) acfg[p] = 4'h0;
        for (int i = 0; i < 3; i++) h[i] = '0;
        d_last = '0;
        cnt = 0;
    endtask

    task automatic step();
        logic [N-1:0] e_out, e_dir, e_in, s_now, s_last;
        #1;
        s_now  = SYNC ? h[1] : soc_in;
        s_last = SYNC ? h[2] : h[0];
        for (int p = 0; p < N; p++) begin
            e_dir[p] = isol_n & acfg[p][0];
            e_out[p] = isol_n & (acfg[p][2] ? d_last[p] : fo[p] ^ acfg[p][1]);
            e_in[p]  = isol_n & ~acfg[p][0] & (acfg[p][3] ? s_last[p] : s_now[p]);
        end
        chk("soc_out", 16'(soc_out), 16'(e_out));
        chk("soc_dir", 16'(soc_dir), 16'(e_dir));
        chk("fabric_inpad", 16'(fi), 16'(e_in));
        chk("ccff_tail", 16'(ccff_tail), 16'(chain_q[L-1]));
        chk("cfg_done", 16'(cfg_done), 16'(cnt == L));
        @(posedge prog_clk);
        if (pReset) model_reset();
        else begin
            for (int p = 0; p < N; p++) d_last[p] = fo[p] ^ acfg[p][1];
            h[2] = h[1];
            h[1] = h[0];
            h[0] = soc_in;
            if (cfg_commit)
                for (int p = 0; p < N; p++)
                    for (int b = 0; b < 4; b++) acfg[p][b] = chain_q[p*4+b];
            if (ccff_en) begin
                chain_q.push_front(ccff_head);
                void'(chain_q.pop_back());
                cnt = (cnt < L) ? cnt + 1 : L;
            end
        end
        @(negedge prog_clk);
    endtask

    task automatic cyc(input logic r, input logic i, input logic e, input logic hd,
                       input logic c, input logic [N-1:0] s, input logic [N-1:0] f);
        pReset = r; isol_n = i; ccff_en = e; ccff_head = hd; cfg_commit = c;
        soc_in = s; fo = f;
        step();
    endtask

    task automatic load(input logic [15:0] w, input logic i, input int nbits);
        for (int k = L - 1; k >= L - nbits; k--)
            cyc(1'b0, i, 1'b1, w[k], 1'b0, N'($urandom), N'($urandom));
    endtask

    initial begin
        pReset = 1'b1; isol_n = 1'b0; ccff_en = 1'b0; ccff_head = 1'b0;
        cfg_commit = 1'b0; soc_in = 4'hF; fo = 4'h0;
        @(posedge prog_clk);
        model_reset();
        @(negedge prog_clk);
        // reset state with soc_in high and pads isolated
        cyc(1, 0, 0, 0, 0, 4'hF, 4'h0);
        chk("t1_inpad", 16'(fi), 16'h0);
        chk("t1_done", 16'(cfg_done), 16'h0);
        cyc(0, 0, 0, 0, 0, 4'hF, 4'h0);
        // all pads DIR=1, OINV=1
        load(16'h3333, 1'b0, 16);
        chk("t2_done", 16'(cfg_done), 16'h1);
        cyc(0, 1, 0, 0, 1, 4'h0, 4'b0101);
        chk("t2_out", 16'(soc_out), 16'b1010);
        chk("t2_dir", 16'(soc_dir), 16'hF);
        // pad2 OREG
        load(16'h3733, 1'b1, 16);
        cyc(0, 1, 0, 0, 1, 4'h0, 4'h0);
        for (int k = 0; k < 8; k++) cyc(0, 1, 0, 0, 0, 4'h0, N'($urandom));
        // pad0 DIR=0, IREG=1
        load(16'h3738, 1'b1, 16);
        cyc(0, 1, 0, 0, 1, 4'h0, 4'h0);
        for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0, 0, 4'h0, 4'h0);
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 0, 4'h1, 4'h0);
        chk("t4_inpad0", 16'(fi[0]), 16'h1);
        // commit together with shift, then overshift to saturate
        cyc(0, 1, 1, 1, 1, 4'h0, 4'h0);
        for (int k = 0; k < 20; k++) cyc(0, 1, 1, 1'($urandom), 0, N'($urandom), N'($urandom));
        // reset mid-load, then full reload with isolation mid-run
        cyc(1, 1, 0, 0, 0, 4'h0, 4'h0);
        load(16'hA5C3, 1'b1, 8);
        cyc(1, 1, 1, 1, 0, 4'h0, 4'h0);
        chk("t6_done_after_rst", 16'(cfg_done), 16'h0);
        load(16'h8C19, 1'b0, 16);
        chk("t6_done", 16'(cfg_done), 16'h1);
        cyc(0, 0, 0, 0, 1, 4'hF, 4'hF);
        chk("t6_isol", 16'({soc_out, soc_dir, fi}), 16'h0);
        // random phase
        for (int k = 0; k < 600; k++)
            cyc(1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 5) != 0),
                1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0),
                N'($urandom), N'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
